rggen_bit_field_hw_update_queue: RTL
====================================

// Module: rggen_bit_field_hw_update_queue
// PURPOSE
//  Upstream feeder for a hardware-settable read/write bit field's i_set/i_value pair.
//  Buffers hardware value updates from a valid/ready producer in a DEPTH-entry FIFO.
//  Issues one update per cycle to the field, only in cycles with no software access.
//  Software writes therefore never lose to a simultaneous hardware set.
//  Also reports occupancy, overflow-attempt and starvation status for a status register.
// PARAMETERS
//  WIDTH        8   bit width of each update value; equals the field WIDTH
//  DEPTH        4   FIFO entries; >= 1, any integer (not restricted to power of two)
//  DEFER_LIMIT  16  consecutive deferred cycles before o_starved sets; >= 1
// PORTS
//  i_clk            in   1                      clock, rising edge
//  i_rst            in   1                      asynchronous reset, active-high
//  i_clear          in   1                      synchronous flush of queue and sticky flags
//  i_sw_access      in   1                      software access to the field this cycle (bit_field_if.valid)
//  i_update_valid   in   1                      producer has an update
//  o_update_ready   out  1                      queue can accept an update
//  i_update_value   in   WIDTH                  update value
//  o_set            out  1                      to field i_set
//  o_value          out  WIDTH                  to field i_value
//  o_count          out  $clog2(DEPTH+1)        entries held
//  o_overflow       out  1                      sticky: valid seen while not ready
//  o_starved        out  1                      sticky: DEFER_LIMIT consecutive deferred cycles
// BEHAVIOUR
//  Reset (async, i_rst=1):
//   - storage, pointers, count, defer counter and sticky flags are all cleared.
//   - o_set=0, o_value='0, o_count=0, o_update_ready=1 (combinational from count).
//  Push:
//   - o_update_ready = (o_count < DEPTH). Readiness never depends on a same-cycle pop.
//   - Accept when i_update_valid & o_update_ready. The entry is written at that edge.
//  Issue (combinational, same cycle as head):
//   - o_set = (o_count != 0) & ~i_sw_access & ~i_clear.
//   - o_value = head entry when o_count != 0, else '0.
//   - The head is popped at the edge where o_set=1.
//  Latency:
//   - An update accepted at edge N is at the head from N+1 if the queue was empty.
//   - Earliest o_set is in cycle N+1; the field takes the value at the end of N+1.
//   - No bypass path exists.
//  Ordering:
//   - Strict FIFO. Updates are never merged or dropped once accepted.
//  Simultaneous push and pop:
//   - Allowed whenever o_count < DEPTH; count is unchanged.
//   - A push of 1 entry into an empty queue cannot pop in the same cycle.
//  Wrap:
//   - Read and write pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1.
//  Full:
//   - o_update_ready=0. A valid in that cycle sets o_overflow. The data is not stored.
//  Empty:
//   - o_set=0 and o_value='0, regardless of i_sw_access.
//  Deferral:
//   - The defer counter increments each cycle with o_count!=0 & i_sw_access.
//   - It clears on any cycle with o_set=1 or with the queue empty.
//   - Reaching DEFER_LIMIT sets o_starved. The counter saturates at DEFER_LIMIT.
//  i_clear:
//   - Empties the queue and clears the defer counter, o_overflow and o_starved at the edge.
//   - A push in the same cycle is discarded; o_update_ready stays as computed.
//   - o_set is forced to 0 in that cycle.
//  Reset mid-operation:
//   - Pending entries are lost. No o_set pulse is emitted at or after reset assertion.
// TESTING
//  1. WIDTH=8: push 0x5A on an empty queue, i_sw_access=0 -> o_set=1 and o_value=0x5A next cycle; o_count returns 0.
//  2. Push 0x11, 0x22, 0x33 back to back with i_sw_access=1 for 5 cycles -> no o_set while held.
//     Then o_set for 3 cycles with 0x11, 0x22, 0x33 in order.
//  3. DEPTH=4: fill with i_sw_access=1 -> o_update_ready=0 at count 4.
//     A 5th valid sets o_overflow; after drain, 4 values arrive in order and the 5th is absent.
//  4. DEFER_LIMIT=16: hold i_sw_access=1 with 1 entry for 15 cycles -> o_starved=0;
//     at the 16th cycle -> o_starved=1. It stays 1 after drain until i_clear.
//  5. Steady push+pop with count=2 for 3*DEPTH cycles -> pointers wrap, count stays 2, no loss or reordering.
//  6. Assert i_rst with 3 entries pending -> o_set=0, o_count=0, o_update_ready=1 immediately (async); no stale value after release.

Source files
------------

// File: rtl/rggen_bit_field_hw_update_queue.sv
// FIFO that feeds hardware updates into a hw-settable bit field. An update is issued
// only in cycles without a software access, so software writes always take precedence.
module rggen_bit_field_hw_update_queue #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int DEFER_LIMIT = 16
)(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_sw_access,
  input  logic                       i_update_valid,
  output logic                       o_update_ready,
  input  logic [WIDTH-1:0]           i_update_value,
  output logic                       o_set,
  output logic [WIDTH-1:0]           o_value,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_starved
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEFER_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [DW-1:0] LIMIT_C  = DW'(DEFER_LIMIT);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [DW-1:0]    r_defer;
  logic             r_overflow;
  logic             r_starved;

  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_defer_next;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < DEPTH_C);
  assign w_push  = i_update_valid & w_ready & ~i_clear;
  assign w_pop   = ~w_empty & ~i_sw_access & ~i_clear;

  assign o_update_ready = w_ready;
  assign o_set          = w_pop;
  assign o_value        = w_empty ? '0 : r_mem[r_rptr];
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_starved      = r_starved;

  // Defer counter restarts whenever the head is issued or nothing is pending.
  always_comb begin
    w_defer_next = r_defer;
    if (w_empty || w_pop) begin
      w_defer_next = '0;
    end else if (r_defer != LIMIT_C) begin
      w_defer_next = r_defer + DW'(1);
    end else begin
      w_defer_next = r_defer;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_update_value;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_defer    <= '0;
      r_overflow <= 1'b0;
      r_starved  <= 1'b0;
    end else if (i_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_defer    <= '0;
      r_overflow <= 1'b0;
      r_starved  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_defer <= w_defer_next;
      if (i_update_valid && !w_ready) begin
        r_overflow <= 1'b1;
      end
      if (w_defer_next == LIMIT_C) begin
        r_starved <= 1'b1;
      end
    end
  end

endmodule
